// File: rtl/qpp_interleaver_pp.sv
// ---------------------------------------------------------------------------
// qpp_interleaver_pp
//   Run-time configurable QPP turbo interleaver with a ping-pong buffer.
//   Each code block (size K, coefficients f1/f2) is written in natural order
//   into one of two banks. It is then read back as out[i] = in[pi(i)], where
//   pi(i) = (f1*i + f2*i^2) mod K. The permutation is generated recursively
//   with compare-subtract modular adders, so no multipliers or ROMs are used.
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   in_valid/in_ready   input handshake (ready = write bank not full)
//   in_data, in_start   natural-order sample, first-sample marker
//   blk_k/f1/f2         block parameters, sampled with the in_start beat
//   out_valid/out_data  permuted output stream (no backpressure)
//   out_start/out_end   first/last output sample of a block
//   err                 one-cycle pulse on a rejected or aborted block
// ---------------------------------------------------------------------------
module qpp_interleaver_pp #(
    parameter int unsigned DATA_W = 1,
    parameter int unsigned KMAX   = 6144,
    parameter int unsigned KMIN   = 40,
    parameter int unsigned ADDR_W = 13
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_start,
    input  logic [ADDR_W-1:0] blk_k,
    input  logic [ADDR_W-1:0] blk_f1,
    input  logic [ADDR_W-1:0] blk_f2,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_start,
    output logic              out_end,
    output logic              err
);

    typedef enum logic {W_IDLE, W_FILL} wstate_t;
    typedef enum logic {R_IDLE, R_RUN}  rstate_t;

    // (a + b) mod k with a single compare-subtract; exact when a, b < k.
    function automatic logic [ADDR_W-1:0] mod_add(input logic [ADDR_W-1:0] a,
                                                  input logic [ADDR_W-1:0] b,
                                                  input logic [ADDR_W-1:0] k);
        logic [ADDR_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, k})
            s = s - {1'b0, k};
        return s[ADDR_W-1:0];
    endfunction

    // Storage and per-bank state
    logic [DATA_W-1:0] mem0 [KMAX];
    logic [DATA_W-1:0] mem1 [KMAX];

    logic [1:0]             full_q;
    logic [1:0][ADDR_W-1:0] k_q;
    logic [1:0][ADDR_W-1:0] f1_q;
    logic [1:0][ADDR_W-1:0] f2_q;

    // Write side
    wstate_t           wstate_q, wstate_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0] mem_waddr;
    logic              mem_we;
    logic              latch_prm;
    logic              set_full;
    logic              err_d;
    logic              accept;
    logic              blk_ok;
    logic [ADDR_W-1:0] wr_k;

    // Read side
    rstate_t           rstate_q, rstate_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] i_q, i_d;
    logic [ADDR_W-1:0] pi_q, pi_d;
    logic [ADDR_W-1:0] g_q, g_d;
    logic [ADDR_W-1:0] step_q, step_d;
    logic              clr_full;
    logic              load;
    logic              load_bank;
    logic              issue;
    logic              last;
    logic              next_full;
    logic [ADDR_W-1:0] rd_k;
    logic [DATA_W-1:0] rd_word;

    // Output registers
    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic              out_start_q;
    logic              out_end_q;
    logic              err_q;

    assign in_ready = ~full_q[wr_ptr_q];
    assign accept   = in_valid & in_ready;
    assign blk_ok   = (blk_k >= ADDR_W'(KMIN)) && (blk_k <= ADDR_W'(KMAX));
    assign wr_k     = k_q[wr_ptr_q];

    // ---------------- write FSM ----------------
    always_comb begin
        wstate_d  = wstate_q;
        wr_ptr_d  = wr_ptr_q;
        wr_addr_d = wr_addr_q;
        mem_we    = 1'b0;
        mem_waddr = wr_addr_q;
        latch_prm = 1'b0;
        set_full  = 1'b0;
        err_d     = 1'b0;
        if (accept) begin
            if (in_start) begin
                // A start in W_FILL aborts the partial block; the new beat is
                // then judged exactly like a start seen in W_IDLE.
                err_d = (wstate_q == W_FILL) || !blk_ok;
                if (blk_ok) begin
                    latch_prm = 1'b1;
                    mem_we    = 1'b1;
                    mem_waddr = '0;
                    wr_addr_d = ADDR_W'(1);
                    wstate_d  = W_FILL;
                end else begin
                    wstate_d  = W_IDLE;
                end
            end else if (wstate_q == W_FILL) begin
                mem_we = 1'b1;
                if (wr_addr_q == wr_k - ADDR_W'(1)) begin
                    set_full = 1'b1;
                    wr_ptr_d = ~wr_ptr_q;
                    wstate_d = W_IDLE;
                end else begin
                    wr_addr_d = wr_addr_q + ADDR_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wstate_q  <= W_IDLE;
            wr_ptr_q  <= 1'b0;
            wr_addr_q <= '0;
            k_q       <= '0;
            f1_q      <= '0;
            f2_q      <= '0;
        end else begin
            wstate_q  <= wstate_d;
            wr_ptr_q  <= wr_ptr_d;
            wr_addr_q <= wr_addr_d;
            if (latch_prm) begin
                k_q[wr_ptr_q]  <= blk_k;
                f1_q[wr_ptr_q] <= blk_f1;
                f2_q[wr_ptr_q] <= blk_f2;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we && !wr_ptr_q)
            mem0[mem_waddr] <= in_data;
        if (mem_we && wr_ptr_q)
            mem1[mem_waddr] <= in_data;
    end

    // Set and clear never target the same bank: the writer only completes a
    // bank that is not full, the reader only frees a full one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full_q <= '0;
        end else begin
            if (set_full)
                full_q[wr_ptr_q] <= 1'b1;
            if (clr_full)
                full_q[rd_ptr_q] <= 1'b0;
        end
    end

    // ---------------- read FSM ----------------
    assign rd_k  = k_q[rd_ptr_q];
    assign issue = (rstate_q == R_RUN);
    assign last  = issue && (i_q == rd_k - ADDR_W'(1));
    // Treat a bank completed on this very edge as full, so a block finishing
    // as the previous one drains follows it without an idle cycle. Its first
    // read happens a cycle later, after the final write has landed.
    assign next_full = full_q[~rd_ptr_q] | (set_full && (wr_ptr_q == ~rd_ptr_q));

    always_comb begin
        rstate_d  = rstate_q;
        rd_ptr_d  = rd_ptr_q;
        i_d       = i_q;
        pi_d      = pi_q;
        g_d       = g_q;
        step_d    = step_q;
        clr_full  = 1'b0;
        load      = 1'b0;
        load_bank = rd_ptr_q;
        if (rstate_q == R_IDLE) begin
            if (full_q[rd_ptr_q]) begin
                load     = 1'b1;
                rstate_d = R_RUN;
            end
        end else begin
            // pi(i+1) = pi(i) + g(i), g(i+1) = g(i) + 2*f2 (all mod K)
            pi_d = mod_add(pi_q, g_q, rd_k);
            g_d  = mod_add(g_q, step_q, rd_k);
            i_d  = i_q + ADDR_W'(1);
            if (last) begin
                clr_full = 1'b1;
                rd_ptr_d = ~rd_ptr_q;
                if (next_full) begin
                    load      = 1'b1;
                    load_bank = ~rd_ptr_q;
                end else begin
                    rstate_d  = R_IDLE;
                end
            end
        end
        if (load) begin
            i_d    = '0;
            pi_d   = '0;
            g_d    = mod_add(f1_q[load_bank], f2_q[load_bank], k_q[load_bank]);
            step_d = mod_add(f2_q[load_bank], f2_q[load_bank], k_q[load_bank]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rstate_q <= R_IDLE;
            rd_ptr_q <= 1'b0;
            i_q      <= '0;
            pi_q     <= '0;
            g_q      <= '0;
            step_q   <= '0;
        end else begin
            rstate_q <= rstate_d;
            rd_ptr_q <= rd_ptr_d;
            i_q      <= i_d;
            pi_q     <= pi_d;
            g_q      <= g_d;
            step_q   <= step_d;
        end
    end

    // Out-of-range addresses only arise from illegal coefficients; they read
    // as zero rather than indexing past the array.
    always_comb begin
        rd_word = '0;
        if (pi_q < ADDR_W'(KMAX))
            rd_word = rd_ptr_q ? mem1[pi_q] : mem0[pi_q];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_start_q <= 1'b0;
            out_end_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            out_valid_q <= issue;
            out_data_q  <= issue ? rd_word : '0;
            out_start_q <= issue && (i_q == '0);
            out_end_q   <= last;
            err_q       <= err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_start = out_start_q;
    assign out_end   = out_end_q;
    assign err       = err_q;

endmodule

// File: tb/tb_qpp_interleaver_pp.sv
// ---------------------------------------------------------------------------
// tb_qpp_interleaver_pp
//   Directed bench for qpp_interleaver_pp. Inputs are driven 1 time unit after
//   the rising edge; outputs are captured on the falling edge into a queue and
//   compared against a direct (non-recursive) QPP formula.
// ---------------------------------------------------------------------------
module tb_qpp_interleaver_pp;

    localparam int DW   = 16;
    localparam int AW   = 13;
    localparam int KMX  = 6144;
    localparam int LIM  = 20000;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          in_start = 1'b0;
    logic [AW-1:0] blk_k = '0;
    logic [AW-1:0] blk_f1 = '0;
    logic [AW-1:0] blk_f2 = '0;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_start;
    logic          out_end;
    logic          err;

    always #5 clk = ~clk;

    qpp_interleaver_pp #(
        .DATA_W (DW),
        .KMAX   (KMX),
        .KMIN   (40),
        .ADDR_W (AW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_start  (in_start),
        .blk_k     (blk_k),
        .blk_f1    (blk_f1),
        .blk_f2    (blk_f2),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_start (out_start),
        .out_end   (out_end),
        .err       (err)
    );

    int unsigned   n_pass  = 0;
    int unsigned   n_total = 0;
    logic [DW+1:0] mon_q[$];
    logic [DW+1:0] exp_q[$];
    int unsigned   err_cnt = 0;
    bit            seen = 1'b0;
    bit            saw_stall = 1'b0;
    time           first_t = 0;
    time           last_t = 0;
    time           last_acc_t = 0;

    // Output monitor: {start, end, data}
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            mon_q.push_back({out_start, out_end, out_data});
            if (!seen) first_t = $time;
            seen   = 1'b1;
            last_t = $time;
        end
        if (err === 1'b1) err_cnt++;
    end

    function automatic void chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input bit st, input int d, input int k, input int f1, input int f2);
        int n = 0;
        in_valid = 1'b1;
        in_start = st;
        in_data  = DW'(d);
        blk_k    = AW'(k);
        blk_f1   = AW'(f1);
        blk_f2   = AW'(f2);
        while (in_ready !== 1'b1 && n < LIM) begin
            saw_stall = 1'b1;
            tick();
            n++;
        end
        if (n >= LIM) chk("ready_timeout", in_ready, 1);
        @(posedge clk);
        last_acc_t = $time;
        #1;
        in_valid = 1'b0;
        in_start = 1'b0;
    endtask

    task automatic send_block(input int k, input int f1, input int f2, input int base,
                              input int nbeats, input bit throttle);
        for (int j = 0; j < nbeats; j++) begin
            if (throttle) repeat ($urandom_range(0, 2)) tick();
            send_beat(j == 0, base + j, k, f1, f2);
        end
    endtask

    task automatic expect_block(input int k, input int f1, input int f2, input int base);
        longint p;
        for (int i = 0; i < k; i++) begin
            p = (longint'(f1) * i + longint'(f2) * i * i) % k;
            exp_q.push_back({i == 0, i == k - 1, DW'(base + int'(p))});
        end
    endtask

    task automatic wait_out(input int budget);
        int n = 0;
        while (mon_q.size() < exp_q.size() && n < budget) begin
            tick();
            n++;
        end
        repeat (6) tick();
    endtask

    task automatic compare(input string tag);
        logic [DW+1:0] e;
        logic [DW+1:0] o;
        chk({tag, "_count"}, mon_q.size(), exp_q.size());
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (mon_q.size() > 0) ? mon_q.pop_front() : 'x;
            chk(tag, o, e);
        end
        mon_q.delete();
        seen = 1'b0;
    endtask

    initial begin
        // ---- reset state ----
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready",  in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data",  out_data, 0);
        chk("rst_out_start", out_start, 0);
        chk("rst_out_end",   out_end, 0);
        chk("rst_err",       err, 0);
        reset = 1'b0;
        tick();

        // ---- 1: single K=40 block, in_data = i ----
        expect_block(40, 3, 10, 0);
        send_block(40, 3, 10, 0, 40, 1'b0);
        wait_out(200);
        chk("t1_latency", first_t - last_acc_t, 25);
        chk("t1_start0", mon_q[0][DW+1], 1);
        chk("t1_d0", mon_q[0][DW-1:0], 0);
        chk("t1_d1", mon_q[1][DW-1:0], 13);
        chk("t1_d2", mon_q[2][DW-1:0], 6);
        chk("t1_d3", mon_q[3][DW-1:0], 19);
        chk("t1_d4", mon_q[4][DW-1:0], 12);
        chk("t1_end39", mon_q[39][DW], 1);
        chk("t1_err", err_cnt, 0);
        compare("t1_sample");

        // ---- 2: three back-to-back K=40 blocks ----
        saw_stall = 1'b0;
        expect_block(40, 3, 10, 100);
        expect_block(40, 3, 10, 200);
        expect_block(40, 3, 10, 300);
        send_block(40, 3, 10, 100, 40, 1'b0);
        send_block(40, 3, 10, 200, 40, 1'b0);
        send_block(40, 3, 10, 300, 40, 1'b0);
        wait_out(400);
        chk("t2_stall", saw_stall, 1);
        chk("t2_contig", (last_t - first_t) / 10, 119);
        compare("t2_sample");

        // ---- 3: K=6144, throttled input ----
        expect_block(6144, 263, 480, 7);
        send_block(6144, 263, 480, 7, 6144, 1'b1);
        wait_out(20000);
        compare("t3_sample");

        // ---- 4: illegal sizes rejected, then K=48 ----
        err_cnt   = 0;
        saw_stall = 1'b0;
        send_beat(1'b1, 0, 39, 3, 10);
        send_beat(1'b1, 0, 6145, 3, 10);
        send_beat(1'b0, 5, 40, 3, 10);
        send_beat(1'b0, 6, 40, 3, 10);
        repeat (60) tick();
        chk("t4_err_cnt", err_cnt, 2);
        chk("t4_no_out", mon_q.size(), 0);
        chk("t4_ready", in_ready, 1);
        chk("t4_no_stall", saw_stall, 0);
        expect_block(48, 7, 12, 1000);
        send_block(48, 7, 12, 1000, 48, 1'b0);
        wait_out(200);
        compare("t4_sample");

        // ---- 5: restart at beat 20 ----
        err_cnt = 0;
        send_block(40, 3, 10, 2000, 20, 1'b0);
        expect_block(40, 3, 10, 3000);
        send_block(40, 3, 10, 3000, 40, 1'b0);
        wait_out(200);
        chk("t5_err_cnt", err_cnt, 1);
        compare("t5_sample");

        // ---- 6: reset in the middle of R_RUN ----
        err_cnt = 0;
        send_block(40, 3, 10, 4000, 40, 1'b0);
        begin
            int n = 0;
            while (mon_q.size() < 5 && n < 200) begin
                tick();
                n++;
            end
        end
        chk("t6_running", out_valid, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_ready", in_ready, 1);
        chk("t6_rst_end", out_end, 0);
        tick();
        tick();
        reset = 1'b0;
        mon_q.delete();
        seen = 1'b0;
        tick();
        repeat (50) tick();
        chk("t6_quiet", mon_q.size(), 0);
        expect_block(40, 3, 10, 5000);
        send_block(40, 3, 10, 5000, 40, 1'b1);
        wait_out(300);
        chk("t6_err", err_cnt, 0);
        compare("t6_sample");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/qpp_interleaver_pp.md
Name: qpp_interleaver_pp

Overview:
- Parametrised, run-time-configurable successor to the fixed two-table turbo interleaver.
- Takes a serial stream of code blocks of any size K up to KMAX, buffers each block in a ping-pong bank pair, and emits it in QPP-permuted order: out[i] = in[pi(i)], with pi(i) = (f1*i + f2*i^2) mod K.
- Permutation addresses are generated recursively. No per-size lookup ROMs.
- Sits between CRC attachment and the constituent encoders. Block size and QPP coefficients arrive per block from the control path.

Parameters:
- DATA_W, 1, bits per sample (1 = hard bits; wider for soft values)
- KMAX, 6144, largest supported block size
- KMIN, 40, smallest supported block size
- ADDR_W, 13, address/size width; must satisfy 2^ADDR_W > KMAX

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  input sample valid
- in_ready  out  1  input sample accepted when in_valid & in_ready
- in_data  in  DATA_W  input sample, natural order
- in_start  in  1  marks the first sample of a block; qualified by in_valid
- blk_k  in  ADDR_W  block size K; sampled with the in_start beat
- blk_f1  in  ADDR_W  QPP f1; sampled with the in_start beat; must be < K
- blk_f2  in  ADDR_W  QPP f2; sampled with the in_start beat; must be < K
- out_valid  out  1  output sample valid; no backpressure
- out_data  out  DATA_W  permuted output sample
- out_start  out  1  high with the first output sample of a block
- out_end  out  1  high with the last output sample of a block
- err  out  1  one-cycle pulse when a block is rejected or aborted

Behaviour:
- Reset (async, immediate): both banks empty; write FSM W_IDLE; read FSM R_IDLE; bank pointers 0.
  - in_ready=1; out_valid=0, out_data=0, out_start=0, out_end=0, err=0.
  - Any partial or buffered block is discarded.
- Storage: two banks, each KMAX x DATA_W, synchronous read with 1-cycle latency.
  - Each bank has a full flag and latched K, f1, f2.
- Write FSM:
  - W_IDLE: an accepted beat with in_start:
    - If KMIN <= blk_k <= KMAX: latch K/f1/f2 into the write bank, write in_data at address 0, go to W_FILL with addr=1.
    - Otherwise: pulse err, drop the beat, stay in W_IDLE.
  - W_IDLE: accepted beats without in_start are dropped silently.
  - W_FILL: each accepted beat is written at addr, then addr++.
    - The beat written at addr=K-1 sets the bank full flag, toggles the write pointer and returns to W_IDLE.
    - in_start during W_FILL: pulse err, abandon the partial block and restart the same bank at address 0 with the new parameters; the restart beat follows the W_IDLE validity rule.
  - in_ready = ~full[write bank].
- Read FSM:
  - R_IDLE: when full[read bank] is set, load i=0, pi=0, g=(f1+f2) mod K, 2f2 mod K; go to R_RUN.
  - R_RUN: issue read address pi each cycle, then update:
    - pi <= (pi+g) mod K
    - g <= (g + 2f2) mod K
  - Each mod is a single compare-subtract, valid because all operands are < K. Datapath width is ADDR_W+1. No multipliers.
  - When address i=K-1 is issued: clear full[read bank] in the same edge, toggle the read pointer, then go to R_IDLE.
    - If the other bank is already full, go straight back into R_RUN, so output is gap-free between blocks.
  - out_valid/out_data follow the issued address by exactly 1 cycle. out_start accompanies i=0 and out_end accompanies i=K-1.
- Latency: last input beat accepted at edge E (sets full) -> read FSM enters R_RUN at E+1 -> first out_valid after E+2.
- Simultaneous events:
  - Write completing one bank and read freeing the other in the same cycle are independent.
  - A freed bank may be written from the next edge; its final registered read has already been captured.
- Coefficients that violate f1,f2 < K produce undefined order but must not hang the FSMs; exactly K outputs are still emitted.

Test Plan:
- Reset, then one block with K=40, f1=3, f2=10 and in_data=i -> out_start, then out_data 0,13,6,19,12,… (all 40 values of (3i+10i^2) mod 40), out_end on the 40th; first out_valid 2 cycles after the last accepted beat.
- Three back-to-back K=40 blocks with in_valid held high -> in_ready drops while both banks are full; outputs contiguous with no out_valid gap between blocks; order and data correct per block.
- K=6144, f1=263, f2=480, randomly throttled in_valid -> output matches a software QPP model over all 6144 samples.
- blk_k=39, then blk_k=6145 -> err pulses, no output, in_ready stays 1; a following valid K=48 block (f1=7, f2=12) is processed correctly.
- in_start at beat 20 of a K=40 block -> err pulse; only the restarted block is output.
- Assert reset mid-R_RUN -> out_valid=0 immediately and in_ready=1; a new K=40 block afterwards outputs correctly.
